// File: rtl/fft_pkg.sv
// Shared definitions for the FFT address controller: FSM encoding and
// default transform geometry.
package fft_pkg;

  localparam int unsigned LOG2N_DEF = 4;
  localparam int unsigned PIPE_DEF  = 2;
  localparam int unsigned SAMPLE_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register that aligns write-back strobe/addresses with
// the read issue; cleared on reset so no stale write survives an abort.
module fft_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIF FFT sequencer: walks stages and butterflies, issues
// operand/twiddle addresses and the delayed write-back strobe.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = LOG2N_DEF,
  parameter int unsigned PIPE  = PIPE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] stage,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_i,
  output logic [LOG2N-1:0] rd_addr_j,
  output logic [LOG2N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_i,
  output logic [LOG2N-1:0] wr_addr_j
);

  localparam int unsigned GAP_W = $clog2(PIPE + 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(PIPE - 1);
  localparam logic [LOG2N-1:0] LAST_STAGE = LOG2N'(LOG2N - 1);
  localparam int unsigned DW = 2 * LOG2N + 1;

  state_e             state_q, state_d;
  logic [LOG2N-2:0]   b_q, b_d;
  logic [LOG2N-1:0]   stage_q, stage_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      stage_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stage_q <= stage_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          b_d     = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        b_d = b_q + 1'b1;
        if (b_q == '1) begin
          state_d = GAP;
          b_d     = '0;
          gap_d   = '0;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (stage_q == LAST_STAGE) begin
            state_d = FIN;
            stage_d = '0;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DIF addressing without division: kmask = span-1, so the masked-off
  // upper bits of b are group*span and doubling them yields 2*span*group.
  logic [LOG2N-2:0] kmask, k;
  logic [LOG2N-1:0] span, addr_i, addr_j;

  always_comb begin
    kmask  = {(LOG2N-1){1'b1}} >> stage_q;
    k      = b_q & kmask;
    span   = {1'b0, kmask} + LOG2N'(1);
    addr_i = {b_q & ~kmask, 1'b0} | {1'b0, k};
    addr_j = addr_i | span;
  end

  assign rd_en     = (state_q == RUN);
  assign busy      = (state_q == RUN) || (state_q == GAP);
  assign done      = (state_q == FIN);
  assign stage     = stage_q;
  assign rd_addr_i = rd_en ? addr_i : '0;
  assign rd_addr_j = rd_en ? addr_j : '0;
  assign tw_addr   = rd_en ? (k << stage_q) : '0;

  logic [DW-1:0] dl_in, dl_out;

  assign dl_in = {rd_en, rd_addr_i, rd_addr_j};

  fft_delay_line #(
    .WIDTH(DW),
    .DEPTH(PIPE)
  ) u_wr_delay (
    .clk  (clk),
    .reset(reset),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign {wr_en, wr_addr_i, wr_addr_j} = dl_out;

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl (16 points, PIPE=2): cycle-exact strobe and
// address timeline, start/reset corner cases and an impulse transform.
module tb_fft_ctrl;

  localparam int unsigned LOG2N = 4;
  localparam int unsigned PIPE  = 2;
  localparam int unsigned N     = 16;
  localparam real         PI    = 3.14159265358979;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic             done;
  logic [LOG2N-1:0] stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_i;
  logic [LOG2N-1:0] rd_addr_j;
  logic [LOG2N-2:0] tw_addr;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_i;
  logic [LOG2N-1:0] wr_addr_j;

  fft_ctrl #(
    .LOG2N(LOG2N),
    .PIPE (PIPE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .stage    (stage),
    .rd_en    (rd_en),
    .rd_addr_i(rd_addr_i),
    .rd_addr_j(rd_addr_j),
    .tw_addr  (tw_addr),
    .wr_en    (wr_en),
    .wr_addr_i(wr_addr_i),
    .wr_addr_j(wr_addr_j)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Hand-derived operand pairs and twiddle exponents, [stage][b].
  int exp_i  [4][8] = '{'{0, 1, 2, 3, 4, 5, 6, 7},
                        '{0, 1, 2, 3, 8, 9, 10, 11},
                        '{0, 1, 4, 5, 8, 9, 12, 13},
                        '{0, 2, 4, 6, 8, 10, 12, 14}};
  int exp_j  [4][8] = '{'{8, 9, 10, 11, 12, 13, 14, 15},
                        '{4, 5, 6, 7, 12, 13, 14, 15},
                        '{2, 3, 6, 7, 10, 11, 14, 15},
                        '{1, 3, 5, 7, 9, 11, 13, 15}};
  int exp_tw [4][8] = '{'{0, 1, 2, 3, 4, 5, 6, 7},
                        '{0, 2, 4, 6, 0, 2, 4, 6},
                        '{0, 4, 0, 4, 0, 4, 0, 4},
                        '{0, 0, 0, 0, 0, 0, 0, 0}};

  real mem_re [N];
  real mem_im [N];
  real q_yi_re [$];
  real q_yi_im [$];
  real q_yj_re [$];
  real q_yj_im [$];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs for cycle t after a start sampled at cycle 0.
  task automatic expect_cycle(input int t);
    int s;
    int b;
    bit rd;
    bit wr;
    rd = (t >= 1 && t <= 40 && ((t - 1) % 10) < 8);
    wr = (t >= 3 && t <= 42 && ((t - 3) % 10) < 8);
    check($sformatf("busy@%0d", t), int'(busy), int'(t >= 1 && t <= 40));
    check($sformatf("done@%0d", t), int'(done), int'(t == 41));
    check($sformatf("rd_en@%0d", t), int'(rd_en), int'(rd));
    check($sformatf("wr_en@%0d", t), int'(wr_en), int'(wr));
    if (t >= 1 && t <= 40) begin
      check($sformatf("stage@%0d", t), int'(stage), (t - 1) / 10);
    end
    if (rd) begin
      s = (t - 1) / 10;
      b = (t - 1) % 10;
      check($sformatf("rd_addr_i@%0d", t), int'(rd_addr_i), exp_i[s][b]);
      check($sformatf("rd_addr_j@%0d", t), int'(rd_addr_j), exp_j[s][b]);
      check($sformatf("tw_addr@%0d", t), int'(tw_addr), exp_tw[s][b]);
    end
    if (wr) begin
      s = (t - 3) / 10;
      b = (t - 3) % 10;
      check($sformatf("wr_addr_i@%0d", t), int'(wr_addr_i), exp_i[s][b]);
      check($sformatf("wr_addr_j@%0d", t), int'(wr_addr_j), exp_j[s][b]);
    end
  endtask

  task automatic expect_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_stage"}, int'(stage), 0);
    check({tag, "_rd_en"}, int'(rd_en), 0);
    check({tag, "_rd_addr_i"}, int'(rd_addr_i), 0);
    check({tag, "_rd_addr_j"}, int'(rd_addr_j), 0);
    check({tag, "_tw_addr"}, int'(tw_addr), 0);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_wr_addr_i"}, int'(wr_addr_i), 0);
    check({tag, "_wr_addr_j"}, int'(wr_addr_j), 0);
  endtask

  // External butterfly + memory: read operands on rd_en, write results
  // back at the addresses presented with wr_en.
  task automatic golden_step();
    real ar, ai, br, bi, wr_c, wi_c, dr, di;
    if (wr_en) begin
      if (q_yi_re.size() == 0) begin
        check("bfly_queue_empty", 0, 1);
      end else begin
        mem_re[wr_addr_i] = q_yi_re.pop_front();
        mem_im[wr_addr_i] = q_yi_im.pop_front();
        mem_re[wr_addr_j] = q_yj_re.pop_front();
        mem_im[wr_addr_j] = q_yj_im.pop_front();
      end
    end
    if (rd_en) begin
      ar   = mem_re[rd_addr_i];
      ai   = mem_im[rd_addr_i];
      br   = mem_re[rd_addr_j];
      bi   = mem_im[rd_addr_j];
      wr_c = $cos(2.0 * PI * real'(tw_addr) / real'(N));
      wi_c = -$sin(2.0 * PI * real'(tw_addr) / real'(N));
      dr   = ar - br;
      di   = ai - bi;
      q_yi_re.push_back(ar + br);
      q_yi_im.push_back(ai + bi);
      q_yj_re.push_back(dr * wr_c - di * wi_c);
      q_yj_im.push_back(dr * wi_c + di * wr_c);
    end
  endtask

  function automatic int bitrev4(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      if (((v >> i) & 1) != 0) r = r | (1 << (3 - i));
    end
    return r;
  endfunction

  // Start sampled at the edge ending cycle 0; observes cycles 1..ncyc.
  // abort_at > 0 raises reset during that cycle and stops there.
  task automatic run_transform(input bit golden, input int ncyc, input int abort_at);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int t = 1; t <= ncyc; t++) begin
      @(negedge clk);
      expect_cycle(t);
      if (golden) golden_step();
      if (t == abort_at) begin
        reset = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    expect_zero("idle");

    // Impulse of amplitude N at index 0 through the full transform.
    for (int i = 0; i < int'(N); i++) begin
      mem_re[i] = 0.0;
      mem_im[i] = 0.0;
    end
    mem_re[0] = real'(N);
    run_transform(1'b1, 45, 0);
    check("bfly_queue_drained", q_yi_re.size(), 0);
    for (int k = 0; k < int'(N); k++) begin
      check($sformatf("bin_re[%0d]x1000", k), int'(mem_re[bitrev4(k)] * 1000.0 / real'(N)), 1000);
      check($sformatf("bin_im[%0d]x1000", k), int'(mem_im[bitrev4(k)] * 1000.0 / real'(N)), 0);
    end

    // start held high: one transform, next one only after IDLE (reads at 43).
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int t = 1; t <= 50; t++) begin
      @(negedge clk);
      expect_cycle((t <= 42) ? t : t - 42);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    expect_zero("held_abort");
    reset = 1'b0;

    // Reset during cycle 15 with start also high: abort wins, then silence.
    run_transform(1'b0, 15, 15);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    expect_zero("abort16");
    reset = 1'b0;
    for (int t = 17; t <= 60; t++) begin
      @(negedge clk);
      expect_zero($sformatf("abort%0d", t));
    end

    // A fresh start after the abort reproduces the full timeline.
    run_transform(1'b0, 45, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_ctrl.md
FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 Parameter LOG2N, default 4, sets log2 of the transform size (N = 2^LOG2N points, N/2 butterflies per stage).
REQ-002 Parameter PIPE, default 2, sets cycles from read issue to write-back (1 memory read latency + 1 butterfly output register).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request one full in-place transform.
REQ-006 busy  output  1  high while a transform is in progress.
REQ-007 done  output  1  one-cycle pulse after the final write-back.
REQ-008 stage  output  LOG2N-bit  index of the current read stage.
REQ-009 rd_en  output  1  data-memory read strobe for the butterfly operand pair.
REQ-010 rd_addr_i, rd_addr_j  output  LOG2N each  upper and lower operand addresses.
REQ-011 tw_addr  output  LOG2N-1  twiddle ROM index (exponent k of W_N^k), valid with rd_en.
REQ-012 wr_en  output  1  write-back strobe for yi/yj results.
REQ-013 wr_addr_i, wr_addr_j  output  LOG2N each  write-back addresses (rd addresses delayed PIPE cycles).

Function
REQ-014 FSM states: IDLE, RUN, GAP, FIN.
REQ-015 IDLE->RUN when start=1; start in any other state is ignored.
REQ-016 In RUN, rd_en=1 every cycle; butterfly counter b runs 0..N/2-1; last b of a stage -> GAP.
REQ-017 GAP lasts exactly PIPE cycles with rd_en=0; then RUN (next stage, b=0) or, after the last stage, FIN.
REQ-018 FIN lasts one cycle, asserts done=1 and busy=0, then -> IDLE.
REQ-019 Radix-2 DIF addressing: span = N>>(stage+1); group = b/span; k = b mod span; rd_addr_i = 2*span*group + k; rd_addr_j = rd_addr_i + span; tw_addr = k<<stage.
REQ-020 Address arithmetic is shift/mask only; no dividers or multipliers.
REQ-021 wr_en, wr_addr_i and wr_addr_j equal rd_en, rd_addr_i and rd_addr_j delayed exactly PIPE cycles through a shift register.
REQ-022 A stage's reads never start before every write of the previous stage has completed (the GAP guarantees this); no read-after-write hazard.
REQ-023 busy=1 from the first RUN cycle through the last GAP cycle.
REQ-024 Timing (LOG2N=4, PIPE=2, start sampled at cycle 0): reads in cycles 1-8, 11-18, 21-28, 31-38; writes in cycles 3-10, 13-20, 23-30, 33-40; done in cycle 41.
REQ-025 Output ordering is stage-major and b ascending; no other ordering is permitted.

Reset
REQ-026 Reset -> IDLE; b=0; stage=0; delay pipeline cleared.
REQ-027 Reset value of every output is 0: busy, done, stage, rd_en, all addresses, tw_addr, wr_en.
REQ-028 Reset mid-transform aborts immediately, with no further rd_en or wr_en pulses and no done pulse.
REQ-029 Reset has priority over start in the same cycle.

Structure
REQ-030 Shared package fft_pkg holds the FSM state encoding, LOG2N/PIPE defaults and the 16-bit sample width.
REQ-031 One sub-module, fft_delay_line (parameterised width and depth), implements the PIPE-cycle write-address/strobe delay.
REQ-032 Address generation and the FSM live in fft_ctrl; the butterfly datapath and memories are external.

Verification
REQ-033 Start at cycle 0 -> rd_en pulses as in REQ-024; stage-0 pairs are (0,8),(1,9)..(7,15) with tw 0..7; done pulse at cycle 41.
REQ-034 Stage 2 check -> pairs (0,2),(1,3),(4,6),(5,7),(8,10),(9,11),(12,14),(13,15) with tw 0,4,0,4,0,4,0,4.
REQ-035 Stage 3 check -> pairs (0,1),(2,3)..(14,15) with tw all 0; wr addresses match rd addresses 2 cycles later.
REQ-036 start held high continuously from cycle 0 -> exactly one transform (done at cycle 41); the next transform starts only from IDLE, with reads resuming at cycle 43.
REQ-037 Reset asserted at cycle 15 -> from cycle 16 all outputs are 0, no done pulse; a new start then reproduces REQ-033.
REQ-038 Golden model: drive fft_ctrl, memory and the butterfly with a 16-point impulse at index 0 -> all bins equal after bit-reverse reordering (scaled by 1/N).
